// File: rtl/pw_checker_if.sv
// Keypad-side bundle of pw_checker: key strobes in, result pulses and status out.
interface pw_checker_if;
    logic       key_vld;
    logic [3:0] key_code;
    logic       mode_set;
    logic       unlock;
    logic       fail;
    logic       set_done;
    logic [3:0] digit_cnt;
    logic       locked;

    modport master (
        output key_vld, key_code, mode_set,
        input  unlock, fail, set_done, digit_cnt, locked
    );

    modport slave (
        input  key_vld, key_code, mode_set,
        output unlock, fail, set_done, digit_cnt, locked
    );
endinterface

// File: rtl/pw_checker.sv
// Keypad password verifier feeding the door-hold delay stage: unlock / fail / set_done pulses.
// Optional macro LOCKOUT_EN adds a LOCK_CYCLES lockout after MAX_FAIL consecutive failures.
module pw_checker #(
    parameter int          DIGITS      = 4,
    parameter logic [31:0] PW_DEFAULT  = 32'h0000_1234,
    parameter int          MAX_FAIL    = 3,
    parameter int          LOCK_CYCLES = 1000
) (
    input logic         clk,
    input logic         n_rst,
    pw_checker_if.slave kp
);
    localparam int         W         = 4 * DIGITS;
    localparam logic [3:0] DIGITS_C  = 4'(DIGITS);
    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_CLEAR = 4'hB;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ENTRY   = 2'd1;
    localparam logic [1:0] S_SET_NEW = 2'd2;
    localparam logic [1:0] S_LOCKED  = 2'd3;

    if (DIGITS < 1 || DIGITS > 8 || MAX_FAIL < 1 || LOCK_CYCLES < 1) begin : g_param_check
        $error("pw_checker: parameter out of range");
    end

    logic [1:0]   state_q, state_d;
    logic [W-1:0] buf_q, buf_d;
    logic [W-1:0] pw_q, pw_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         ovf_q, ovf_d;
    logic         mode_q, mode_d;
    logic         unlock_q, unlock_d;
    logic         fail_q, fail_d;
    logic         set_done_q, set_done_d;

    logic         is_digit, is_enter, is_clear;
    logic         full, match, to_idle;
    logic         lock_due, leave_lock;
    logic [W-1:0] buf_shift;

    assign is_digit  = kp.key_vld && (kp.key_code <= 4'd9);
    assign is_enter  = kp.key_vld && (kp.key_code == KEY_ENTER);
    assign is_clear  = kp.key_vld && (kp.key_code == KEY_CLEAR);
    assign full      = (cnt_q == DIGITS_C);
    assign match     = full && !ovf_q && (buf_q == pw_q);
    // First digit typed ends up in the most significant nibble.
    assign buf_shift = (buf_q << 4) | W'(kp.key_code);

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d    = state_q;
        buf_d      = buf_q;
        pw_d       = pw_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        mode_d     = mode_q;
        unlock_d   = 1'b0;
        fail_d     = 1'b0;
        set_done_d = 1'b0;
        to_idle    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (lock_due) begin
                    state_d = S_LOCKED;
                end else if (is_digit) begin
                    mode_d  = kp.mode_set;
                    buf_d   = W'(kp.key_code);
                    cnt_d   = 4'd1;
                    ovf_d   = 1'b0;
                    state_d = S_ENTRY;
                end
            end
            S_ENTRY, S_SET_NEW: begin
                if (is_clear) begin
                    to_idle = 1'b1;
                end else if (is_enter) begin
                    to_idle = 1'b1;
                    if (state_q == S_SET_NEW) begin
                        if (full && !ovf_q) begin
                            pw_d       = buf_q;
                            set_done_d = 1'b1;
                        end else begin
                            fail_d = 1'b1;
                        end
                    end else if (match && mode_q) begin
                        to_idle = 1'b0;
                        buf_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = S_SET_NEW;
                    end else if (match) begin
                        unlock_d = 1'b1;
                    end else begin
                        fail_d = 1'b1;
                    end
                end else if (is_digit) begin
                    if (full) begin
                        ovf_d = 1'b1;
                    end else begin
                        buf_d = buf_shift;
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                if (leave_lock) state_d = S_IDLE;
            end
        endcase

        if (to_idle) begin
            state_d = S_IDLE;
            buf_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= S_IDLE;
            buf_q      <= '0;
            // NOTE: the password register is reset too; a changed code is volatile by design.
            pw_q       <= PW_DEFAULT[W-1:0];
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            mode_q     <= 1'b0;
            unlock_q   <= 1'b0;
            fail_q     <= 1'b0;
            set_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            pw_q       <= pw_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            mode_q     <= mode_d;
            unlock_q   <= unlock_d;
            fail_q     <= fail_d;
            set_done_q <= set_done_d;
        end
    end

`ifdef LOCKOUT_EN
    localparam int             FCW       = $clog2(MAX_FAIL + 1);
    localparam int             LCW       = $clog2(LOCK_CYCLES + 1);
    localparam logic [FCW-1:0] FAIL_MAX  = FCW'(MAX_FAIL);
    localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_CYCLES - 1);

    logic [FCW-1:0] fcnt_q, fcnt_d;
    logic [LCW-1:0] lcnt_q, lcnt_d;

    // Lockout is entered from IDLE, so it starts the cycle after the fail pulse.
    assign lock_due   = (fcnt_q == FAIL_MAX);
    assign leave_lock = (state_q == S_LOCKED) && (lcnt_q == LOCK_LAST);

    always_comb begin
        fcnt_d = fcnt_q;
        if (unlock_d || leave_lock) begin
            fcnt_d = '0;
        end else if (fail_d && (state_q == S_ENTRY) && (fcnt_q != FAIL_MAX)) begin
            fcnt_d = fcnt_q + 1'b1;
        end
        lcnt_d = (state_q == S_LOCKED) ? lcnt_q + 1'b1 : '0;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            fcnt_q <= '0;
            lcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_d;
            lcnt_q <= lcnt_d;
        end
    end

    assign kp.locked = (state_q == S_LOCKED);
`else
    assign lock_due   = 1'b0;
    assign leave_lock = 1'b1;
    assign kp.locked  = 1'b0;
`endif

    assign kp.unlock    = unlock_q;
    assign kp.fail      = fail_q;
    assign kp.set_done  = set_done_q;
    assign kp.digit_cnt = cnt_q;
endmodule

// File: tb/tb_pw_checker.sv
// Self-checking bench for pw_checker: ENTER strobes push expected pulses, a negedge monitor pops them.
`timescale 1ns/1ps
module tb_pw_checker;
    localparam logic [3:0] K_ENTER  = 4'hA;
    localparam logic [3:0] K_CLEAR  = 4'hB;
    localparam logic [2:0] P_NONE   = 3'b000;
    localparam logic [2:0] P_UNLOCK = 3'b100;
    localparam logic [2:0] P_FAIL   = 3'b010;
    localparam logic [2:0] P_SET    = 3'b001;

    typedef struct {
        logic [2:0] pulses;
        int         due;
        string      name;
    } exp_t;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t exp_q[$];

    pw_checker_if kp();

    pw_checker #(
        .DIGITS     (4),
        .PW_DEFAULT (32'h0000_1234),
        .MAX_FAIL   (3),
        .LOCK_CYCLES(20)
    ) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .kp   (kp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: pulses must appear exactly on the due cycle and nowhere else.
    always @(negedge clk) begin
        logic [2:0] obs;
        obs = {kp.unlock, kp.fail, kp.set_done};
        if (n_rst && exp_q.size() > 0 && exp_q[0].due == cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e.pulses)
                $display("FAIL %s: {unlock,fail,set_done}=%b expected %b (cycle %0d)", e.name, obs, e.pulses, cyc);
            else
                n_pass++;
        end else if (n_rst) begin
            n_checks++;
            if (obs !== P_NONE)
                $display("FAIL stray_pulse: {unlock,fail,set_done}=%b expected %b (cycle %0d)", obs, P_NONE, cyc);
            else
                n_pass++;
        end
    end

    task automatic press(input logic [3:0] code, input logic mode);
        @(negedge clk);
        kp.key_vld  = 1'b1;
        kp.key_code = code;
        kp.mode_set = mode;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            kp.key_vld  = 1'b0;
            kp.key_code = 4'h0;
            kp.mode_set = 1'b0;
        end
    endtask

    task automatic enter(input logic [2:0] expect_p, input string name);
        press(K_ENTER, 1'b0);
        exp_q.push_back('{expect_p, cyc + 1, name});
    endtask

    task automatic type_code(input logic [31:0] code, input int n, input logic mode);
        for (int i = 0; i < n; i++)
            press(code[4*(n-1-i) +: 4], (i == 0) ? mode : 1'b0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic test_reset();
        kp.key_vld  = 1'b0;
        kp.key_code = 4'h0;
        kp.mode_set = 1'b0;
        #23;
        n_checks++;
        if ({kp.unlock, kp.fail, kp.set_done} !== P_NONE)
            $display("FAIL reset_pulses: got %b expected %b", {kp.unlock, kp.fail, kp.set_done}, P_NONE);
        else n_pass++;
        n_checks++;
        if (kp.digit_cnt !== 4'd0) $display("FAIL reset_digit_cnt: got %0d expected 0", kp.digit_cnt);
        else n_pass++;
        n_checks++;
        if (kp.locked !== 1'b0) $display("FAIL reset_locked: got %b expected 0", kp.locked);
        else n_pass++;
        @(negedge clk);
        n_rst = 1'b1;
        idle(2);
    endtask

    task automatic test_unlock();
        type_code(32'h1234, 4, 1'b0);
        idle(1);
        n_checks++;
        if (kp.digit_cnt !== 4'd4) $display("FAIL unlock_digit_cnt4: got %0d expected 4", kp.digit_cnt);
        else n_pass++;
        enter(P_UNLOCK, "unlock_1234");
        idle(2);
        n_checks++;
        if (kp.digit_cnt !== 4'd0) $display("FAIL unlock_digit_cnt0: got %0d expected 0", kp.digit_cnt);
        else n_pass++;
    endtask

    task automatic test_wrong();
        type_code(32'h123, 3, 1'b0);
        enter(P_FAIL, "short_code");
        idle(2);
        type_code(32'h12345, 5, 1'b0);
        idle(1);
        n_checks++;
        if (kp.digit_cnt !== 4'd4) $display("FAIL overflow_saturate: got %0d expected 4", kp.digit_cnt);
        else n_pass++;
        enter(P_FAIL, "overflow_code");
        idle(2);
        type_code(32'h1234, 4, 1'b0);
        enter(P_UNLOCK, "unlock_after_fails");
        idle(2);
        type_code(32'h1243, 4, 1'b0);
        enter(P_FAIL, "wrong_digits");
        idle(2);
        type_code(32'h1234, 4, 1'b0);
        enter(P_UNLOCK, "unlock_after_wrong");
        idle(2);
    endtask

    task automatic test_clear();
        type_code(32'h12, 2, 1'b0);
        press(K_CLEAR, 1'b0);
        idle(1);
        n_checks++;
        if (kp.digit_cnt !== 4'd0) $display("FAIL clear_digit_cnt: got %0d expected 0", kp.digit_cnt);
        else n_pass++;
        type_code(32'h1234, 4, 1'b0);
        enter(P_UNLOCK, "unlock_after_clear");
        idle(2);
        enter(P_NONE, "enter_in_idle");
        press(K_CLEAR, 1'b0);
        press(4'hC, 1'b0);
        idle(2);
        n_checks++;
        if (kp.digit_cnt !== 4'd0) $display("FAIL idle_ignores_keys: got %0d expected 0", kp.digit_cnt);
        else n_pass++;
        type_code(32'h12, 2, 1'b0);
        press(4'hF, 1'b0);
        type_code(32'h34, 2, 1'b0);
        enter(P_UNLOCK, "invalid_key_ignored");
        idle(2);
    endtask

    task automatic test_mode_ignored();
        press(4'h1, 1'b0);
        press(4'h2, 1'b1);
        press(4'h3, 1'b1);
        press(4'h4, 1'b1);
        enter(P_UNLOCK, "mode_late_ignored");
        idle(2);
    endtask

    task automatic test_back_to_back();
        type_code(32'h1234, 4, 1'b0);
        enter(P_UNLOCK, "b2b_first");
        type_code(32'h1234, 4, 1'b0);
        enter(P_UNLOCK, "b2b_second");
        type_code(32'h9999, 4, 1'b0);
        enter(P_FAIL, "b2b_wrong");
        idle(2);
    endtask

    task automatic test_change();
        type_code(32'h1234, 4, 1'b1);
        enter(P_NONE, "change_old_ok");
        idle(1);
        n_checks++;
        if (kp.digit_cnt !== 4'd0) $display("FAIL set_new_cnt0: got %0d expected 0", kp.digit_cnt);
        else n_pass++;
        type_code(32'h9876, 4, 1'b0);
        enter(P_SET, "change_set_done");
        idle(2);
        type_code(32'h1234, 4, 1'b0);
        enter(P_FAIL, "old_code_rejected");
        idle(2);
        type_code(32'h9876, 4, 1'b0);
        enter(P_UNLOCK, "new_code_unlocks");
        idle(2);
    endtask

    task automatic test_set_new_bad();
        type_code(32'h1111, 4, 1'b1);
        enter(P_FAIL, "change_wrong_old");
        idle(2);
        type_code(32'h9876, 4, 1'b1);
        enter(P_NONE, "change2_old_ok");
        type_code(32'h55, 2, 1'b0);
        enter(P_FAIL, "set_new_short");
        idle(2);
        type_code(32'h9876, 4, 1'b1);
        enter(P_NONE, "change3_old_ok");
        type_code(32'h55555, 5, 1'b0);
        enter(P_FAIL, "set_new_overflow");
        idle(2);
        type_code(32'h9876, 4, 1'b0);
        enter(P_UNLOCK, "pw_unchanged");
        idle(2);
    endtask

    task automatic test_reset_mid_entry();
        type_code(32'h12, 2, 1'b0);
        idle(1);
        n_checks++;
        if (kp.digit_cnt !== 4'd2) $display("FAIL mid_entry_cnt2: got %0d expected 2", kp.digit_cnt);
        else n_pass++;
        #2 n_rst = 1'b0;
        #1;
        n_checks++;
        if (kp.digit_cnt !== 4'd0) $display("FAIL async_reset_cnt: got %0d expected 0", kp.digit_cnt);
        else n_pass++;
        @(negedge clk);
        n_rst = 1'b1;
        type_code(32'h1234, 4, 1'b0);
        enter(P_UNLOCK, "unlock_after_reset");
        idle(2);
    endtask

    task automatic test_change_then_reset();
        type_code(32'h1234, 4, 1'b1);
        enter(P_NONE, "chg_old_ok");
        type_code(32'h4321, 4, 1'b0);
        enter(P_SET, "chg_set_4321");
        idle(2);
        pulse_reset();
        type_code(32'h4321, 4, 1'b0);
        enter(P_FAIL, "volatile_pw_rejected");
        idle(2);
        type_code(32'h1234, 4, 1'b0);
        enter(P_UNLOCK, "default_pw_restored");
        idle(2);
    endtask

`ifdef LOCKOUT_EN
    task automatic test_lockout();
        int lk;
        pulse_reset();
        for (int k = 0; k < 3; k++) begin
            type_code(32'h1111, 4, 1'b0);
            enter(P_FAIL, "lockout_wrong");
            if (k < 2) idle(2);
        end
        idle(1);
        n_checks++;
        if (kp.locked !== 1'b0) $display("FAIL lock_not_during_pulse: got %b expected 0", kp.locked);
        else n_pass++;
        idle(1);
        n_checks++;
        if (kp.locked !== 1'b1) $display("FAIL lock_asserted: got %b expected 1", kp.locked);
        else n_pass++;
        lk = 1;
        for (int i = 0; i < 4; i++) begin
            press(4'(i + 1), 1'b0);
            if (kp.locked === 1'b1) lk++;
        end
        enter(P_NONE, "lockout_ignores_code");
        if (kp.locked === 1'b1) lk++;
        for (int i = 0; i < 60 && kp.locked === 1'b1; i++) begin
            idle(1);
            if (kp.locked === 1'b1) lk++;
        end
        n_checks++;
        if (lk !== 20) $display("FAIL lock_duration: got %0d cycles expected 20", lk);
        else n_pass++;
        n_checks++;
        if (kp.digit_cnt !== 4'd0) $display("FAIL lock_digit_cnt: got %0d expected 0", kp.digit_cnt);
        else n_pass++;
        type_code(32'h1234, 4, 1'b0);
        enter(P_UNLOCK, "unlock_after_lockout");
        idle(2);
    endtask
`endif

    initial begin
        test_reset();
        test_unlock();
        test_wrong();
        test_clear();
        test_mode_ignored();
        test_back_to_back();
        test_change();
        test_set_new_bad();
        test_reset_mid_entry();
        test_change_then_reset();
`ifdef LOCKOUT_EN
        test_lockout();
`endif
        idle(3);
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d pending expected 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
